// File: rtl/reg_file_18.sv
// rtl/reg_file_18.sv - DEPTH x WIDTH register file, two combinational read ports, sequential bulk clear; optional forwarding via REG_FILE_BYPASS_EN
module reg_file_18 #(
  parameter int WIDTH  = 18,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              clear,
  output logic              busy,
  output logic              wr_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WIPE = 1'b1;

  // Extra bit so DEPTH itself is representable when DEPTH == 2^ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_wr_err;

  logic              w_wr_ok;
  logic [WIDTH-1:0]  w_rd_a;
  logic [WIDTH-1:0]  w_rd_b;

  // A write lands only when idle and in range; everything else is a rejection.
  assign w_wr_ok = wr_en && (r_state == S_IDLE) && ({1'b0, wr_addr} < DEPTH_W);

  // Wipe sequencer: one entry per cycle, terminates on the last valid index.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_state <= S_WIPE;
            r_idx   <= '0;
          end
        end
        default: begin
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      endcase
    end
  end

  // Storage array: wipe has priority, writes are already blocked while wiping.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (r_state == S_WIPE) begin
        r_mem[r_idx] <= '0;
      end else if (w_wr_ok) begin
        r_mem[wr_addr] <= wr_data;
      end
    end
  end

  // Rejection flag lasts exactly the cycle after the offending edge.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en && !w_wr_ok;
    end
  end

  // Read port A: out-of-range addresses read zero; optional write-first forward.
  always_comb begin
    w_rd_a = '0;
    if ({1'b0, rd_addr_a} < DEPTH_W) begin
      w_rd_a = r_mem[rd_addr_a];
    end
`ifdef REG_FILE_BYPASS_EN
    if (w_wr_ok && (wr_addr == rd_addr_a)) begin
      w_rd_a = wr_data;
    end
`endif
  end

  // Read port B: same behaviour as port A, fully independent.
  always_comb begin
    w_rd_b = '0;
    if ({1'b0, rd_addr_b} < DEPTH_W) begin
      w_rd_b = r_mem[rd_addr_b];
    end
`ifdef REG_FILE_BYPASS_EN
    if (w_wr_ok && (wr_addr == rd_addr_b)) begin
      w_rd_b = wr_data;
    end
`endif
  end

  assign rd_data_a = w_rd_a;
  assign rd_data_b = w_rd_b;
  assign busy      = (r_state == S_WIPE);
  assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_reg_file_18.sv
// tb/tb_reg_file_18.sv - directed table-driven bench for reg_file_18 (DEPTH 16 and DEPTH 12 instances)
module tb_reg_file_18;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [17:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [17:0] rd_data_a;
  logic [3:0]  rd_addr_b;
  logic [17:0] rd_data_b;
  logic        clear;
  logic        busy;
  logic        wr_err;

  logic        e_wr_en;
  logic [3:0]  e_wr_addr;
  logic [17:0] e_wr_data;
  logic [3:0]  e_rd_addr_a;
  logic [17:0] e_rd_data_a;
  logic [3:0]  e_rd_addr_b;
  logic [17:0] e_rd_data_b;
  logic        e_clear;
  logic        e_busy;
  logic        e_wr_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [17:0] wd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [17:0] ea;
    logic [17:0] eb;
    logic        ebusy;
    logic        eerr;
  } vec_t;

  vec_t vecs [7];

  always #5 CLK = ~CLK;

  reg_file_18 #(.WIDTH(18), .DEPTH(16), .ADDR_W(4)) u_dut (
    .CLK(CLK), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .clear(clear), .busy(busy), .wr_err(wr_err)
  );

  reg_file_18 #(.WIDTH(18), .DEPTH(12), .ADDR_W(4)) u_dut12 (
    .CLK(CLK), .rst_n(rst_n), .wr_en(e_wr_en), .wr_addr(e_wr_addr), .wr_data(e_wr_data),
    .rd_addr_a(e_rd_addr_a), .rd_data_a(e_rd_data_a), .rd_addr_b(e_rd_addr_b), .rd_data_b(e_rd_data_b),
    .clear(e_clear), .busy(e_busy), .wr_err(e_wr_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int bcnt;
    int n;

    vecs[0] = '{1'b1, 4'd3,  18'h2AAAA, 4'd0,  4'd1,  18'h00000, 18'h00000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'd15, 18'h0F0F3, 4'd3,  4'd14, 18'h2AAAA, 18'h00000, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 4'd0,  18'h00000, 4'd3,  4'd15, 18'h2AAAA, 18'h0F0F3, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 4'd3,  18'h00001, 4'd15, 4'd15, 18'h0F0F3, 18'h0F0F3, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 4'd0,  18'h00000, 4'd3,  4'd0,  18'h00001, 18'h00000, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'd0,  18'h3FFFF, 4'd3,  4'd3,  18'h00001, 18'h00001, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 4'd0,  18'h00000, 4'd0,  4'd15, 18'h3FFFF, 18'h0F0F3, 1'b0, 1'b0};

    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = 4'd3; rd_addr_b = 4'd15; clear = 1'b0;
    e_wr_en = 1'b0; e_wr_addr = '0; e_wr_data = '0; e_rd_addr_a = '0; e_rd_addr_b = '0; e_clear = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_rd_a", rd_data_a, 0);
    chk("rst_rd_b", rd_data_b, 0);
    rst_n = 1'b1;
    next_cycle();

    // Table-driven writes and reads: outputs sampled before the edge of each step
    for (int i = 0; i < 7; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      @(negedge CLK);
      chk($sformatf("vec%0d_rd_a", i), rd_data_a, vecs[i].ea);
      chk($sformatf("vec%0d_rd_b", i), rd_data_b, vecs[i].eb);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
      chk($sformatf("vec%0d_wr_err", i), wr_err, vecs[i].eerr);
      next_cycle();
    end
    wr_en = 1'b0;

    // DEPTH=12: out-of-range writes rejected, out-of-range reads are zero
    e_wr_en = 1'b1; e_wr_addr = 4'd11; e_wr_data = 18'h12345;
    next_cycle();
    e_wr_addr = 4'd13; e_wr_data = 18'h3FFFF;
    @(negedge CLK);
    chk("d12_err_valid", e_wr_err, 0);
    next_cycle();
    e_wr_addr = 4'd12; e_rd_addr_a = 4'd13; e_rd_addr_b = 4'd11;
    @(negedge CLK);
    chk("d12_err_13", e_wr_err, 1);
    chk("d12_rd_13", e_rd_data_a, 0);
    chk("d12_rd_11", e_rd_data_b, 18'h12345);
    next_cycle();
    e_wr_en = 1'b0; e_rd_addr_a = 4'd12;
    @(negedge CLK);
    chk("d12_err_12", e_wr_err, 1);
    chk("d12_rd_12", e_rd_data_a, 0);
    next_cycle();
    @(negedge CLK);
    chk("d12_err_clr", e_wr_err, 0);
    next_cycle();

    // Fill every entry with its index, then run a wipe with interference
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 18'(i);
      next_cycle();
    end
    wr_en = 1'b0;
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    bcnt = 0;
    for (int c = 1; c <= 20; c++) begin
      wr_en = (c == 2); wr_addr = 4'd7; wr_data = 18'h31234;
      clear = (c == 3);
      rd_addr_a = (c == 6) ? 4'd4 : 4'd2;
      rd_addr_b = (c == 6) ? 4'd10 : 4'd6;
      @(negedge CLK);
      if (busy) bcnt++;
      if (c == 1) chk("wipe_busy_first", busy, 1);
      if (c == 2) chk("wipe_wr_err_pre", wr_err, 0);
      if (c == 3) chk("wipe_wr_err", wr_err, 1);
      if (c == 4) chk("wipe_wr_err_once", wr_err, 0);
      if (c == 6) begin
        chk("mid_wipe_e4", rd_data_a, 0);
        chk("mid_wipe_e10", rd_data_b, 10);
      end
      if (c == 7) begin
        chk("mid_wipe_e2", rd_data_a, 0);
        chk("mid_wipe_e6", rd_data_b, 6);
      end
      if (c == 16) chk("wipe_busy_last", busy, 1);
      if (c == 17) chk("wipe_busy_fall", busy, 0);
      next_cycle();
    end
    wr_en = 1'b0; clear = 1'b0;
    chk("wipe_busy_len", bcnt, 16);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(i + 8);
      @(negedge CLK);
      chk($sformatf("wiped_e%0d", i), rd_data_a, 0);
      chk($sformatf("wiped_e%0d", i + 8), rd_data_b, 0);
      next_cycle();
    end

    // Level clear: one idle cycle between back-to-back wipes
    clear = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      @(negedge CLK);
      if (c == 0)  chk("lvl_busy_c0", busy, 0);
      if (c == 16) chk("lvl_busy_c16", busy, 1);
      if (c == 17) chk("lvl_busy_gap", busy, 0);
      if (c == 18) chk("lvl_busy_restart", busy, 1);
      next_cycle();
    end
    clear = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      next_cycle();
      n++;
    end
    chk("lvl_wipe_done", busy, 0);

    // Same-cycle write and read of address 5
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 18'h15555; rd_addr_a = 4'd5; rd_addr_b = 4'd0;
    @(negedge CLK);
`ifdef REG_FILE_BYPASS_EN
    chk("bypass_same_cycle", rd_data_a, 18'h15555);
`else
    chk("bypass_same_cycle", rd_data_a, 18'h00000);
`endif
    next_cycle();
    wr_en = 1'b0;
    @(negedge CLK);
    chk("bypass_next_cycle", rd_data_a, 18'h15555);
    next_cycle();

    // Write and clear at the same idle edge: write lands, wipe starts
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 18'h00001; clear = 1'b1;
    next_cycle();
    wr_en = 1'b0; clear = 1'b0; rd_addr_a = 4'd9; rd_addr_b = 4'd5;
    @(negedge CLK);
    chk("wc_busy", busy, 1);
    chk("wc_wr_err", wr_err, 0);
    chk("wc_entry9", rd_data_a, 18'h00001);
    chk("wc_entry5", rd_data_b, 18'h15555);
    next_cycle();

    // Asynchronous reset between edges in the middle of the wipe
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_entry9", rd_data_a, 0);
    chk("arst_entry5", rd_data_b, 0);
    @(negedge CLK);
    rst_n = 1'b1;
    next_cycle();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 18'h00ABC; rd_addr_a = 4'd2;
    next_cycle();
    wr_en = 1'b0;
    @(negedge CLK);
    chk("post_rst_write", rd_data_a, 18'h00ABC);
    chk("post_rst_wr_err", wr_err, 0);
    chk("post_rst_busy", busy, 0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
